// File: rtl/inst_mem_loader_if.sv
// Byte-stream handshake between a boot byte source and inst_mem_loader.
// master = byte source, slave = loader.
interface inst_mem_loader_if;
  logic       rx_valid_i;
  logic [7:0] rx_data_i;
  logic       rx_ready_o;

  modport master (
    output rx_valid_i,
    output rx_data_i,
    input  rx_ready_o
  );

  modport slave (
    input  rx_valid_i,
    input  rx_data_i,
    output rx_ready_o
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Boot-time instruction memory loader.
// Receives a length-prefixed byte stream (N[7:0], N[15:8], then 4*N data bytes),
// packs little-endian 32-bit words and writes them from address 0 upward. Owns the
// memory address/write port while busy; otherwise the core PC drives the address.
// Optional feature: define INST_LOADER_CHECKSUM_EN to expect one trailing XOR
// checksum byte over the length and data bytes; err_o flags a mismatch.
module inst_mem_loader #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  inst_mem_loader_if.slave        rx,
  input  logic [31:0]             pc_i,
  output logic [31:0]             mem_addr_o,
  output logic [31:0]             mem_wdata_o,
  output logic                    mem_wr_en_o,
  output logic                    cpu_hold_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    ovf_o,
  output logic                    err_o
);

  localparam logic [16:0] MEM_WORDS = 17'(MEM_BYTES / 4);

`ifdef INST_LOADER_CHECKSUM_EN
  localparam logic CSUM_EN = 1'b1;
`else
  localparam logic CSUM_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE
  } state_t;

  // State entered once the last data word is written (or N = 0).
  localparam state_t S_TAIL = CSUM_EN ? S_CSUM : S_DONE;

  state_t      state_q;
  logic        rx_ready_q;
  logic        busy_q;
  logic        wr_en_q;
  logic        done_q;
  logic        ovf_q;
  logic [31:0] wdata_q;
  logic [31:0] addr_q;
  logic [15:0] count_q;
  logic [15:0] len_q;
  logic [1:0]  byte_idx_q;
  logic        xfer;
  logic [15:0] len_full;

`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
  logic        err_q;
`endif

  assign xfer     = rx.rx_valid_i & rx_ready_q;
  assign len_full = {rx.rx_data_i, len_q[7:0]};

  // Load sequencer; all handshake and status outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      wdata_q    <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      len_q      <= '0;
      byte_idx_q <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q    <= S_LEN_LO;
            rx_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            addr_q     <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            err_q      <= 1'b0;
`endif
          end
        end

        S_LEN_LO: begin
          if (xfer) begin
            len_q[7:0] <= rx.rx_data_i;
            state_q    <= S_LEN_HI;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_q     <= rx.rx_data_i;
`endif
          end
        end

        S_LEN_HI: begin
          if (xfer) begin
            len_q[15:8] <= rx.rx_data_i;
            ovf_q       <= ({1'b0, len_full} > MEM_WORDS);
            byte_idx_q  <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_q      <= csum_q ^ rx.rx_data_i;
`endif
            if (len_full == '0) begin
              state_q    <= S_TAIL;
              rx_ready_q <= CSUM_EN;
              busy_q     <= CSUM_EN;
              done_q     <= ~CSUM_EN;
            end else begin
              state_q <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (xfer) begin
            wdata_q[{byte_idx_q, 3'b000} +: 8] <= rx.rx_data_i;
            byte_idx_q <= byte_idx_q + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_q     <= csum_q ^ rx.rx_data_i;
`endif
            if (byte_idx_q == 2'd3) begin
              state_q    <= S_WRITE;
              rx_ready_q <= 1'b0;
              // Words beyond capacity are still consumed, but never written.
              wr_en_q    <= ({1'b0, count_q} < MEM_WORDS);
            end
          end
        end

        S_WRITE: begin
          wr_en_q <= 1'b0;
          addr_q  <= addr_q + 32'd4;
          count_q <= count_q + 16'd1;
          if (count_q + 16'd1 == len_q) begin
            state_q    <= S_TAIL;
            rx_ready_q <= CSUM_EN;
            busy_q     <= CSUM_EN;
            done_q     <= ~CSUM_EN;
          end else begin
            state_q    <= S_DATA;
            rx_ready_q <= 1'b1;
          end
        end

`ifdef INST_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (xfer) begin
            err_q      <= (rx.rx_data_i != csum_q);
            state_q    <= S_DONE;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end
        end
`endif

        default: begin
          state_q    <= S_IDLE;
          rx_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          wr_en_q    <= 1'b0;
        end
      endcase
    end
  end

  // Memory port ownership: loader address while busy, core fetch address otherwise.
  always_comb begin
    mem_addr_o = busy_q ? addr_q : pc_i;
  end

  assign rx.rx_ready_o = rx_ready_q;
  assign mem_wdata_o   = wdata_q;
  assign mem_wr_en_o   = wr_en_q;
  assign busy_o        = busy_q;
  assign cpu_hold_o    = busy_q;
  assign done_o        = done_q;
  assign ovf_o         = ovf_q;
`ifdef INST_LOADER_CHECKSUM_EN
  assign err_o         = err_q;
`else
  assign err_o         = 1'b0;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader (MEM_BYTES = 8, i.e. 2 words, so overflow is easy to hit).
// Honours INST_LOADER_CHECKSUM_EN the same way the design does.
module tb_inst_mem_loader;
  localparam int unsigned MEMB = 8;
  localparam int unsigned MW   = MEMB / 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] pc_i = 32'h40;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_wr_en_o;
  logic        cpu_hold_o;
  logic        busy_o;
  logic        done_o;
  logic        ovf_o;
  logic        err_o;

  inst_mem_loader_if rx_if ();

  inst_mem_loader #(.MEM_BYTES(MEMB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .rx          (rx_if),
    .pc_i        (pc_i),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_wr_en_o (mem_wr_en_o),
    .cpu_hold_o  (cpu_hold_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .ovf_o       (ovf_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [63:0] cap[$];   // observed writes {addr, data}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural monitor ----------------
  // Tracks the load purely from accepted-byte counts and checks outputs every cycle.
  logic        mon_loading = 1'b0, mon_done = 1'b0, mon_ovf = 1'b0, mon_err = 1'b0, mon_wr = 1'b0;
  int unsigned mon_bytes = 0, mon_words = 0, mon_n = 0;
  logic [7:0]  mon_lo = '0, mon_x = '0;
  logic [31:0] mon_word = '0;

  task automatic mon_data_end();
`ifndef INST_LOADER_CHECKSUM_EN
    mon_loading = 1'b0;
    mon_done    = 1'b1;
`endif
  endtask

  initial begin
    forever begin
      logic       next_wr;
      logic [7:0] b;
      int unsigned pos;
      @(negedge clk);
      if (!rst_n) begin
        mon_loading = 1'b0; mon_done = 1'b0; mon_ovf = 1'b0; mon_err = 1'b0; mon_wr = 1'b0;
      end else begin
        chk("hold_eq_busy", 32'(cpu_hold_o), 32'(busy_o));
        chk("busy", 32'(busy_o), 32'(mon_loading));
        chk("done", 32'(done_o), 32'(mon_done));
        chk("ovf", 32'(ovf_o), 32'(mon_ovf));
        chk("err", 32'(err_o), 32'(mon_err));
        if (!mon_loading) begin
          chk("idle_addr_pc", mem_addr_o, pc_i);
          chk("idle_ready", 32'(rx_if.rx_ready_o), 32'd0);
          chk("idle_wr", 32'(mem_wr_en_o), 32'd0);
        end else if (mon_wr) begin
          chk("write_ready", 32'(rx_if.rx_ready_o), 32'd0);
          chk("write_en", 32'(mem_wr_en_o), 32'(mon_words < MW));
          if (mon_words < MW) begin
            chk("write_addr", mem_addr_o, 32'(mon_words * 4));
            chk("write_data", mem_wdata_o, mon_word);
          end
        end else begin
          chk("rx_ready", 32'(rx_if.rx_ready_o), 32'd1);
          chk("no_wr", 32'(mem_wr_en_o), 32'd0);
          chk("busy_addr", mem_addr_o, 32'(mon_words * 4));
        end
        if (mem_wr_en_o) cap.push_back({mem_addr_o, mem_wdata_o});

        next_wr = 1'b0;
        if (!mon_loading) begin
          if (start_i) begin
            mon_loading = 1'b1; mon_done = 1'b0; mon_ovf = 1'b0; mon_err = 1'b0;
            mon_bytes = 0; mon_words = 0; mon_x = '0;
          end
        end else if (mon_wr) begin
          mon_words++;
          if (mon_words == mon_n) mon_data_end();
        end else if (rx_if.rx_valid_i) begin
          b = rx_if.rx_data_i;
          if (mon_bytes == 0) begin
            mon_lo = b; mon_x ^= b;
          end else if (mon_bytes == 1) begin
            mon_x ^= b;
            mon_n = {16'd0, b, mon_lo};
            mon_ovf = (mon_n > MW);
            if (mon_n == 0) mon_data_end();
          end else if (mon_bytes < 2 + 4 * mon_n) begin
            mon_x ^= b;
            pos = (mon_bytes - 2) % 4;
            mon_word[8*pos +: 8] = b;
            if (pos == 3) next_wr = 1'b1;
          end else begin
            mon_err = (b != mon_x);
            mon_loading = 1'b0;
            mon_done = 1'b1;
          end
          mon_bytes++;
        end
        mon_wr = next_wr;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // mode 0: valid always, 1: valid toggles, 2: random gaps plus stray start pulses mid-load.
  task automatic send_stream(input logic [7:0] q[$], input int unsigned mode);
    int unsigned idx = 0;
    int unsigned cyc = 0;
    logic tog = 1'b1;
    logic acc;
    while (idx < q.size() && cyc < 40 * q.size() + 40) begin
      case (mode)
        0:       rx_if.rx_valid_i = 1'b1;
        1:       begin rx_if.rx_valid_i = tog; tog = ~tog; end
        default: rx_if.rx_valid_i = ($urandom_range(0, 2) != 0);
      endcase
      rx_if.rx_data_i = rx_if.rx_valid_i ? q[idx] : 8'($urandom);
      if (mode == 2 && idx + 1 < q.size() && $urandom_range(0, 7) == 0) start_i = 1'b1;
      @(negedge clk);
      #1 acc = rx_if.rx_valid_i && rx_if.rx_ready_o;
      tick();
      start_i = 1'b0;
      if (acc) idx++;
      cyc++;
    end
    rx_if.rx_valid_i = 1'b0;
    chk("stream_accepted", idx, q.size());
  endtask

  task automatic wait_done();
    int unsigned c = 0;
    while (!done_o && c < 40) begin
      tick();
      c++;
    end
    chk("done_reached", 32'(done_o), 32'd1);
  endtask

  // Appends the checksum byte when the feature is built in; bad=1 corrupts it.
  task automatic run_load(input logic [7:0] body[$], input int unsigned mode, input logic bad);
    logic [7:0] q[$];
    logic [7:0] x;
    q = body;
    x = '0;
    foreach (body[j]) x ^= body[j];
`ifdef INST_LOADER_CHECKSUM_EN
    q.push_back(bad ? ~x : x);
`endif
    cap.delete();
    pulse_start();
    send_stream(q, mode);
    wait_done();
  endtask

  task automatic check_err(input logic bad);
`ifdef INST_LOADER_CHECKSUM_EN
    chk("err_o_final", 32'(err_o), 32'(bad));
`else
    chk("err_o_final", 32'(err_o), 32'(1'b0 & bad));
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  body[$];
    logic [31:0] words[$];
    int unsigned n, nexp, mode;
    logic        bad;

    rx_if.rx_valid_i = 1'b0;
    rx_if.rx_data_i  = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_hold", 32'(cpu_hold_o), 32'd0);
    chk("rst_ready", 32'(rx_if.rx_ready_o), 32'd0);
    chk("rst_wr", 32'(mem_wr_en_o), 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_addr", mem_addr_o, 32'h40);
    chk("rst_flags", {29'd0, done_o, ovf_o, err_o}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Two-word directed load, valid held high, then with valid toggling.
    for (int unsigned m = 0; m < 2; m++) begin
      body = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
      run_load(body, m, 1'b0);
      chk("dir_wcount", cap.size(), 2);
      if (cap.size() == 2) begin
        chk("dir_w0_addr", cap[0][63:32], 32'h0);
        chk("dir_w0_data", cap[0][31:0], 32'h00100513);
        chk("dir_w1_addr", cap[1][63:32], 32'h4);
        chk("dir_w1_data", cap[1][31:0], 32'h00200593);
      end
      chk("dir_hold", 32'(cpu_hold_o), 32'd0);
      chk("dir_addr_pc", mem_addr_o, pc_i);
      check_err(1'b0);
    end

    // Empty load.
    body = '{8'h00, 8'h00};
    run_load(body, 0, 1'b0);
    chk("n0_wcount", cap.size(), 0);
    chk("n0_ovf", 32'(ovf_o), 32'd0);

    // Overflow: three words into a two-word memory.
    body = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
             8'h99, 8'hAA, 8'hBB, 8'hCC};
    run_load(body, 0, 1'b0);
    chk("ovf_flag", 32'(ovf_o), 32'd1);
    chk("ovf_wcount", cap.size(), 2);
    if (cap.size() == 2) begin
      chk("ovf_w0", cap[0][31:0], 32'h44332211);
      chk("ovf_w1_addr", cap[1][63:32], 32'h4);
      chk("ovf_w1", cap[1][31:0], 32'h88776655);
    end

    // Checksum: good then wrong (err_o stays 0 when the feature is not built).
    body = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load(body, 0, 1'b0);
    check_err(1'b0);
    chk("cs_word", cap.size() == 1 ? cap[0][31:0] : 32'hX, 32'hDDCCBBAA);
    run_load(body, 1, 1'b1);
    check_err(1'b1);

    // Reset in the middle of the first data word.
    cap.delete();
    pulse_start();
    body = '{8'h02, 8'h00, 8'hAA, 8'hBB};
    send_stream(body, 0);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_hold", 32'(cpu_hold_o), 32'd0);
    chk("mid_rst_ready", 32'(rx_if.rx_ready_o), 32'd0);
    chk("mid_rst_wr", 32'(mem_wr_en_o), 32'd0);
    chk("mid_rst_wdata", mem_wdata_o, 32'd0);
    chk("mid_rst_flags", {29'd0, done_o, ovf_o, err_o}, 32'd0);
    chk("mid_rst_addr", mem_addr_o, 32'h40);
    tick();
    rst_n = 1'b1;
    tick();
    body = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    run_load(body, 0, 1'b0);
    chk("post_rst_wcount", cap.size(), 1);
    if (cap.size() == 1) begin
      chk("post_rst_addr", cap[0][63:32], 32'h0);
      chk("post_rst_data", cap[0][31:0], 32'h04030201);
    end

    // Randomized loads against the word-level model.
    for (int unsigned r = 0; r < 30; r++) begin
      n    = $urandom_range(0, 4);
      mode = $urandom_range(0, 2);
      bad  = 1'($urandom_range(0, 1));
      pc_i = $urandom;
      words.delete();
      body.delete();
      body.push_back(8'(n));
      body.push_back(8'(n >> 8));
      for (int unsigned i = 0; i < n; i++) begin
        words.push_back($urandom);
        for (int unsigned k = 0; k < 4; k++) body.push_back(words[i][8*k +: 8]);
      end
      run_load(body, mode, bad);
      nexp = (n < MW) ? n : MW;
      chk("rnd_wcount", cap.size(), nexp);
      for (int unsigned i = 0; i < nexp && i < cap.size(); i++) begin
        chk("rnd_waddr", cap[i][63:32], 32'(i * 4));
        chk("rnd_wdata", cap[i][31:0], words[i]);
      end
      chk("rnd_ovf", 32'(ovf_o), 32'(n > MW));
      chk("rnd_hold", 32'(cpu_hold_o), 32'd0);
      check_err(bad);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
